sc_life_loss_ctrl: RTL

SC_LIFE_LOSS_CTRL -- requirements
Module: sc_life_loss_ctrl

---
 rtl/sc_life_loss_pkg.sv | 39 +++
 rtl/sc_respawn_timer.sv | 48 ++++
 rtl/sc_life_loss_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sc_life_loss_pkg.sv
// ---------------------------------------------------------------------------
// sc_life_loss_pkg
//   Shared definitions for the frog life-loss controller.
//   - 3-bit state encodings and the matching enum used by the FSM
//   - default game-over lives value and default respawn window length
//   - small helper that says in which state a collision edge may count
// ---------------------------------------------------------------------------
package sc_life_loss_pkg;

  // State encodings; kept as plain localparams so other blocks (debug taps,
  // LED decoders) can compare against them without the enum type.
  localparam logic [2:0] ST_ALIVE    = 3'd0;
  localparam logic [2:0] ST_HIT      = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_RESPAWN  = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  typedef enum logic [2:0] {
    S_ALIVE    = ST_ALIVE,
    S_HIT      = ST_HIT,
    S_SETTLE   = ST_SETTLE,
    S_RESPAWN  = ST_RESPAWN,
    S_GAMEOVER = ST_GAMEOVER
  } state_e;

  // The lives counter resets to 0 and counts down through 7, 6, 5:
  // three losses end the game.
  localparam logic [2:0]  GAMEOVER_VALUE_DEFAULT = 3'd5;

  // One second of invulnerability at 50 MHz.
  localparam int unsigned RESPAWN_CYCLES_DEFAULT = 50_000_000;

  // A collision edge only costs a life while the frog is plainly alive;
  // every other state is either mid-decrement, invulnerable or finished.
  function automatic logic hit_accepted(input state_e s);
    return (s == S_ALIVE);
  endfunction

endpackage

// File: rtl/sc_respawn_timer.sv
// ---------------------------------------------------------------------------
// sc_respawn_timer
//   Loadable down-counter used to time the invulnerable respawn window.
//   Load has priority over counting; the counter stops at zero.
//
//   Ports
//     SC_LIVES_COUNTER_CLOCK_50     in   system clock, rising edge
//     SC_LIVES_COUNTER_RESET_InHigh in   asynchronous active-high reset (count=0)
//     load_InHigh                   in   load load_value_In this cycle
//     load_value_In                 in   WIDTH-bit value to load
//     enable_InHigh                 in   decrement by one this cycle
//     zero_OutHigh                  out  count register is zero
// ---------------------------------------------------------------------------
module sc_respawn_timer #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             SC_LIVES_COUNTER_CLOCK_50,
  input  logic             SC_LIVES_COUNTER_RESET_InHigh,
  input  logic             load_InHigh,
  input  logic [WIDTH-1:0] load_value_In,
  input  logic             enable_InHigh,
  output logic             zero_OutHigh
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_InHigh) begin
      count_d = load_value_In;
    end else if (enable_InHigh && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge SC_LIVES_COUNTER_CLOCK_50 or posedge SC_LIVES_COUNTER_RESET_InHigh) begin
    if (SC_LIVES_COUNTER_RESET_InHigh) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Derived straight from the register, so it carries no input path.
  assign zero_OutHigh = (count_q == '0);

endmodule

// File: rtl/sc_life_loss_ctrl.sv
// ---------------------------------------------------------------------------
// sc_life_loss_ctrl
//   Turns frog/hazard collisions into life losses. A rising edge of the
//   collision level while alive and running issues one active-low decrement
//   request to the lives counter, waits one cycle for the counter to settle,
//   then either ends the game or starts an invulnerable respawn window.
//
//   Ports
//     SC_LIVES_COUNTER_CLOCK_50     in   system clock, rising edge
//     SC_LIVES_COUNTER_RESET_InHigh in   asynchronous active-high reset
//     collision_InHigh              in   level: frog overlaps a hazard
//     enable_InHigh                 in   game running (low = paused)
//     lives_In                      in   lives counter register value
//     upcount_OutLow                out  one-cycle active-low decrement request
//     respawn_OutHigh               out  one-cycle pulse: frog back to start
//     invulnerable_OutHigh          out  level, high during respawn window
//     game_over_OutHigh             out  level, sticky until reset
//
//   All outputs are flops loaded from the next-state decode, so each output
//   lines up with the state it belongs to and nothing is combinational from
//   the inputs.
// ---------------------------------------------------------------------------
module sc_life_loss_ctrl
  import sc_life_loss_pkg::*;
#(
  parameter int unsigned              LIVES_WIDTH    = 3,
  parameter logic [LIVES_WIDTH-1:0]   GAMEOVER_VALUE = LIVES_WIDTH'(GAMEOVER_VALUE_DEFAULT),
  parameter int unsigned              RESPAWN_CYCLES = RESPAWN_CYCLES_DEFAULT,
  parameter int unsigned              TIMER_WIDTH    = 26
) (
  input  logic                   SC_LIVES_COUNTER_CLOCK_50,
  input  logic                   SC_LIVES_COUNTER_RESET_InHigh,
  input  logic                   collision_InHigh,
  input  logic                   enable_InHigh,
  input  logic [LIVES_WIDTH-1:0] lives_In,
  output logic                   upcount_OutLow,
  output logic                   respawn_OutHigh,
  output logic                   invulnerable_OutHigh,
  output logic                   game_over_OutHigh
);

  // Timer counts RESPAWN_CYCLES-1 down to 0; the exit decision is taken on
  // the zero cycle, which gives exactly RESPAWN_CYCLES enabled cycles.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(RESPAWN_CYCLES - 1);

  state_e state_q;
  state_e state_d;

  logic   coll_prev_q;
  logic   hit;

  logic   timer_load;
  logic   timer_en;
  logic   timer_zero;

  logic   upcount_q;
  logic   upcount_d;
  logic   respawn_q;
  logic   respawn_d;
  logic   invulnerable_q;
  logic   invulnerable_d;
  logic   game_over_q;
  logic   game_over_d;

  // Edge detect against the previous sample. The sample is refreshed every
  // cycle regardless of state, so a collision still held high when the frog
  // comes back to ALIVE does not look like a new hit.
  assign hit = collision_InHigh && !coll_prev_q;

  // -------------------------------------------------------------------------
  // Next-state and timer control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      S_ALIVE: begin
        // A paused edge is simply dropped; the edge is gone next cycle.
        if (hit && enable_InHigh && hit_accepted(state_q)) begin
          state_d = S_HIT;
        end
      end

      S_HIT: begin
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        // lives_In already reflects the decrement issued during HIT.
        if (lives_In == GAMEOVER_VALUE) begin
          state_d = S_GAMEOVER;
        end else begin
          state_d    = S_RESPAWN;
          timer_load = 1'b1;
        end
      end

      S_RESPAWN: begin
        // Pausing freezes both the countdown and the exit.
        if (enable_InHigh) begin
          if (timer_zero) begin
            state_d = S_ALIVE;
          end else begin
            timer_en = 1'b1;
          end
        end
      end

      S_GAMEOVER: begin
        state_d = S_GAMEOVER;
      end

      default: begin
        state_d = S_ALIVE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    upcount_d      = (state_d != S_HIT);
    // The only way into RESPAWN is from SETTLE, which is exactly when the
    // timer is loaded, so the load doubles as the entry marker.
    respawn_d      = timer_load;
    invulnerable_d = (state_d == S_RESPAWN);
    game_over_d    = (state_d == S_GAMEOVER);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge SC_LIVES_COUNTER_CLOCK_50 or posedge SC_LIVES_COUNTER_RESET_InHigh) begin
    if (SC_LIVES_COUNTER_RESET_InHigh) begin
      state_q        <= S_ALIVE;
      coll_prev_q    <= 1'b0;
      upcount_q      <= 1'b1;
      respawn_q      <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      coll_prev_q    <= collision_InHigh;
      upcount_q      <= upcount_d;
      respawn_q      <= respawn_d;
      invulnerable_q <= invulnerable_d;
      game_over_q    <= game_over_d;
    end
  end

  assign upcount_OutLow       = upcount_q;
  assign respawn_OutHigh      = respawn_q;
  assign invulnerable_OutHigh = invulnerable_q;
  assign game_over_OutHigh    = game_over_q;

  // -------------------------------------------------------------------------
  // Respawn window timer
  // -------------------------------------------------------------------------
  sc_respawn_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_respawn_timer (
    .SC_LIVES_COUNTER_CLOCK_50     (SC_LIVES_COUNTER_CLOCK_50),
    .SC_LIVES_COUNTER_RESET_InHigh (SC_LIVES_COUNTER_RESET_InHigh),
    .load_InHigh                   (timer_load),
    .load_value_In                 (TIMER_LOAD),
    .enable_InHigh                 (timer_en),
    .zero_OutHigh                  (timer_zero)
  );

endmodule
